// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_stage_skid_if : valid/ready handshake bundle for a stage    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  // Environment side: produces upstream payload, consumes downstream payload.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy, stall_cnt
  );

  // Stage side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_stage_skid : pipeline register with 2-entry skid buffer,    |
// | flush and saturating stall counter.                  Rev 1.0     |
// +------------------------------------------------------------------+
module pipe_stage_skid #(
  parameter int                DATA_W     = 32,
  parameter int                CNT_W      = 16,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  input  wire logic         flush_i,
  pipe_stage_skid_if.slave  bus
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic w_in_ready;
  logic w_in_xfer;
  logic w_out_xfer;

  // Ready never looks at out_ready, so upstream sees no combinational path.
  assign w_in_ready = ~s_valid_q & ~flush_i;
  assign w_in_xfer  = bus.in_valid & w_in_ready;
  assign w_out_xfer = m_valid_q & bus.out_ready;

  always_comb begin
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    s_valid_d   = s_valid_q;
    s_data_d    = s_data_q;
    stall_cnt_d = stall_cnt_q;

    if (m_valid_q && !bus.out_ready && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + C_CNT_ONE;
    end

    if (flush_i) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_data_d  = RESET_DATA;
    end else if (!m_valid_q) begin
      if (w_in_xfer) begin
        m_valid_d = 1'b1;
        m_data_d  = bus.in_data;
      end
    end else if (w_out_xfer) begin
      if (s_valid_q) begin
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (w_in_xfer) begin
        m_data_d  = bus.in_data;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (w_in_xfer) begin
      s_valid_d = 1'b1;
      s_data_d  = bus.in_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_valid_q   <= 1'b0;
      m_data_q    <= RESET_DATA;
      s_valid_q   <= 1'b0;
      s_data_q    <= RESET_DATA;
      stall_cnt_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      s_valid_q   <= s_valid_d;
      s_data_q    <= s_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = m_valid_q;
  assign bus.out_data  = m_data_q;
  assign bus.occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};
  assign bus.stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// Bench for pipe_stage_skid: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_stage_skid;

  localparam int          DW = 32;
  localparam logic [31:0] RD = 32'h0BAD_F00D;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.DATA_W(DW), .CNT_W(16)) bus16 ();
  pipe_stage_skid_if #(.DATA_W(DW), .CNT_W(4))  bus4 ();

  assign bus4.in_valid  = bus16.in_valid;
  assign bus4.in_data   = bus16.in_data;
  assign bus4.out_ready = bus16.out_ready;

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(16), .RESET_DATA(RD)) dut16 (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus16.slave)
  );

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(4), .RESET_DATA(RD)) dut4 (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus4.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two held words.
  logic [31:0] q[$];
  logic [31:0] od;
  int unsigned cnt16, cnt4;

  always @(posedge clk or posedge rst) begin : model
    bit ox, ix;
    if (rst) begin
      q.delete();
      od    = RD;
      cnt16 = 0;
      cnt4  = 0;
    end else begin
      ox = (q.size() > 0) && bus16.out_ready;
      ix = bus16.in_valid && (q.size() < 2) && !flush;
      if ((q.size() > 0) && !bus16.out_ready) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt4 < 15) cnt4++;
      end
      if (flush) begin
        q.delete();
        od = RD;
      end else begin
        if (ox) void'(q.pop_front());
        if (ix) q.push_back(bus16.in_data);
        if (q.size() > 0) od = q[0];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("out_valid", bus16.out_valid, q.size() > 0);
    chk("out_data",  bus16.out_data, od);
    chk("in_ready",  bus16.in_ready, (q.size() < 2) && !flush);
    chk("occupancy", bus16.occupancy, q.size());
    chk("stall16",   bus16.stall_cnt, cnt16);
    chk("out_data4", bus4.out_data, od);
    chk("stall4",    bus4.stall_cnt, cnt4);
  end

  bit rnd = 1'b0;
  int sent = 0;
  int recv = 0;
  always @(posedge clk) begin
    if (rnd) begin
      if (bus16.in_valid && bus16.in_ready) sent++;
      if (bus16.out_valid && bus16.out_ready) recv++;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, bus16.out_valid, 1'b0);
    chk({tag, "_ready"}, bus16.in_ready, 1'b1);
    chk({tag, "_occ"},   bus16.occupancy, 2'd0);
    chk({tag, "_data"},  bus16.out_data, RD);
    chk({tag, "_stall"}, bus16.stall_cnt, 16'd0);
  endtask

  initial begin
    bus16.in_valid  = 1'b0;
    bus16.in_data   = '0;
    bus16.out_ready = 1'b0;
    #1 rst = 1'b1;
    #1 chk_reset("rst0");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Streaming 1..8 with out_ready held high.
    bus16.in_valid  = 1'b1;
    bus16.in_data   = 32'h1;
    bus16.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #2;
      chk("t1_data", bus16.out_data, 32'(i));
      chk("t1_valid", bus16.out_valid, 1'b1);
      chk("t1_ready", bus16.in_ready, 1'b1);
      @(negedge clk);
      if (i < 8) bus16.in_data = 32'(i + 1);
      else       bus16.in_valid = 1'b0;
    end
    chk("t1_stall", bus16.stall_cnt, 16'd0);

    // Backpressure: A in M, B into S, C held upstream.
    @(negedge clk);
    bus16.in_valid  = 1'b1;
    bus16.in_data   = 32'hA;
    bus16.out_ready = 1'b0;
    @(negedge clk); bus16.in_data = 32'hB;
    @(negedge clk); bus16.in_data = 32'hC;
    repeat (2) @(negedge clk);
    chk("t2_occ", bus16.occupancy, 2'd2);
    chk("t2_ready", bus16.in_ready, 1'b0);
    chk("t2_stall", bus16.stall_cnt, 16'd3);
    chk("t2_dataA", bus16.out_data, 32'hA);
    bus16.out_ready = 1'b1;
    @(posedge clk); #2;
    chk("t2_dataB", bus16.out_data, 32'hB);
    @(posedge clk); #2;
    chk("t2_dataC", bus16.out_data, 32'hC);
    @(negedge clk); bus16.in_valid = 1'b0;
    @(negedge clk);

    // Flush with two entries held.
    bus16.in_valid  = 1'b1;
    bus16.in_data   = 32'hA;
    bus16.out_ready = 1'b0;
    @(negedge clk); bus16.in_data = 32'hB;
    @(negedge clk);
    chk("t3_occ2", bus16.occupancy, 2'd2);
    bus16.in_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #2;
    chk("t3_valid", bus16.out_valid, 1'b0);
    chk("t3_occ0", bus16.occupancy, 2'd0);
    chk("t3_data", bus16.out_data, RD);
    chk("t3_rdy_fl", bus16.in_ready, 1'b0);
    @(negedge clk); flush = 1'b0;
    #1;
    chk("t3_ready", bus16.in_ready, 1'b1);
    chk("t3_stall", bus16.stall_cnt, 16'd5);

    // Counter saturation on the narrow instance.
    bus16.in_valid = 1'b1;
    bus16.in_data  = 32'h44;
    @(negedge clk); bus16.in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("t4_stall16", bus16.stall_cnt, 16'd25);
    chk("t4_stall4", bus4.stall_cnt, 4'd15);

    // Asynchronous reset between edges with two entries held.
    @(negedge clk);
    bus16.in_valid = 1'b1;
    bus16.in_data  = 32'h55;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    chk("t5_occ2", bus16.occupancy, 2'd2);
    #1 rst = 1'b1;
    #1 chk_reset("t5");
    chk("t5_stall4", bus4.stall_cnt, 4'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    bus16.in_valid  = 1'b1;
    bus16.in_data   = 32'h66;
    bus16.out_ready = 1'b1;
    @(posedge clk); #2;
    chk("t5_pvalid", bus16.out_valid, 1'b1);
    chk("t5_pdata", bus16.out_data, 32'h66);
    @(negedge clk); bus16.in_valid = 1'b0;
    @(negedge clk);

    // Random traffic, checked cycle by cycle against the model.
    rnd = 1'b1;
    repeat (10000) begin
      @(negedge clk);
      bus16.in_valid  = 1'($urandom_range(0, 1));
      bus16.in_data   = $urandom;
      bus16.out_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    rnd = 1'b0;
    chk("t6_conserve", 64'(recv), 64'(sent));
    chk("t6_drained", bus16.occupancy, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
